// File: rtl/regfile_pkg.sv
// Shared widths, typedefs and constants for the MIPS register file.
// No logic; no latency; no flow control.
// Imported by the storage top, the read ports and the bench.
package regfile_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: array mux, r0 gating, optional write-through bypass.
// Latency: zero cycles (purely combinational).
// Backpressure: none; the read data is always valid.
module regfile_read_port #(
    parameter int DATA_W    = regfile_pkg::DATA_W,
    parameter int ADDR_W    = regfile_pkg::ADDR_W,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    output logic [DATA_W-1:0] rd_dat
);
    import regfile_pkg::*;

    logic addr_is_zero;
    logic bypass_hit;

    assign addr_is_zero = (rd_addr == ADDR_W'(ZERO_REG));
    // wr_en arrives already qualified with reset and the r0 check.
    assign bypass_hit   = BYPASS_EN && wr_en && (wr_addr == rd_addr);

    always_comb begin
        rd_dat = regs[rd_addr];
        if (bypass_hit) begin
            rd_dat = wr_dat;
        end
        if (addr_is_zero) begin
            rd_dat = '0;
        end
    end

endmodule

// File: rtl/mips_register_file.sv
// 32 x 64-bit MIPS GPR file: two combinational read ports, one synchronous write port.
// Latency: reads zero cycles; writes land on the next rising clk edge.
// Backpressure: none; every write and read is accepted every cycle.
module mips_register_file #(
    parameter int DATA_W    = regfile_pkg::DATA_W,
    parameter int ADDR_W    = regfile_pkg::ADDR_W,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    input  logic [DATA_W-1:0] write_reg_data,
    input  logic [ADDR_W-1:0] read_1_addr,
    input  logic [ADDR_W-1:0] read_2_addr,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic              regWrite_en
);
    import regfile_pkg::*;

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_fire;

    // Reset blocks both the commit and the forwarded value, so reads stay 0 in reset.
    assign wr_fire = rst && regWrite_en && (write_addr != ADDR_W'(ZERO_REG));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_fire) begin
            regs[write_addr] <= write_reg_data;
        end
    end

    regfile_read_port #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BYPASS_EN (BYPASS_EN)
    ) u_rd1 (
        .regs    (regs),
        .rd_addr (read_1_addr),
        .wr_en   (wr_fire),
        .wr_addr (write_addr),
        .wr_dat  (write_reg_data),
        .rd_dat  (read_data_1)
    );

    regfile_read_port #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BYPASS_EN (BYPASS_EN)
    ) u_rd2 (
        .regs    (regs),
        .rd_addr (read_2_addr),
        .wr_en   (wr_fire),
        .wr_addr (write_addr),
        .wr_dat  (write_reg_data),
        .rd_dat  (read_data_2)
    );

endmodule

// File: tb/tb_mips_register_file.sv
// Directed bench for mips_register_file (BYPASS_EN=1) with a per-cycle reference model.
// Inputs change 2 time units after posedge; the model checks both ports at every negedge.
module tb_mips_register_file;
    import regfile_pkg::*;

    logic      clk;
    logic      rst;
    reg_data_t read_data_1;
    reg_data_t read_data_2;
    reg_data_t write_reg_data;
    reg_addr_t read_1_addr;
    reg_addr_t read_2_addr;
    reg_addr_t write_addr;
    logic      regWrite_en;

    int vectors;
    int miscompares;

    reg_data_t model [NUM_REGS];

    mips_register_file #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BYPASS_EN (1'b1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .read_data_1    (read_data_1),
        .read_data_2    (read_data_2),
        .write_reg_data (write_reg_data),
        .read_1_addr    (read_1_addr),
        .read_2_addr    (read_2_addr),
        .write_addr     (write_addr),
        .regWrite_en    (regWrite_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural view: reset or r0 reads zero, a live write to the same index is seen
    // immediately, otherwise the last committed value.
    function automatic reg_data_t exp_rd(input reg_addr_t a);
        if (!rst || a == 0) return '0;
        if (regWrite_en && write_addr != 0 && write_addr == a) return write_reg_data;
        return model[a];
    endfunction

    always @(posedge clk) begin
        if (rst && regWrite_en && write_addr != 0) model[write_addr] = write_reg_data;
    end

    always @(negedge rst) begin
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    end

    task automatic check(input string name, input reg_data_t act, input reg_data_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_rd1", read_data_1, exp_rd(read_1_addr));
        check("model_rd2", read_data_2, exp_rd(read_2_addr));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input reg_addr_t a, input reg_data_t d);
        regWrite_en    = 1'b1;
        write_addr     = a;
        write_reg_data = d;
        step();
        regWrite_en    = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        rst            = 1'b0;
        regWrite_en    = 1'b0;
        write_addr     = '0;
        write_reg_data = '0;
        read_1_addr    = 5'd1;
        read_2_addr    = 5'd2;
        step();
        check("reset_rd1", read_data_1, 64'd0);
        check("reset_rd2", read_data_2, 64'd0);
        rst = 1'b1;
        step();

        for (int i = 1; i < NUM_REGS; i++) begin
            wr(reg_addr_t'(i), {32'hA5A5_0000, 32'(i)});
        end
        read_1_addr = 5'd7;
        read_2_addr = 5'd31;
        #1;
        check("fill_r7",  read_data_1, 64'hA5A5_0000_0000_0007);
        check("fill_r31", read_data_2, 64'hA5A5_0000_0000_001F);

        // Asynchronous reset between edges, with a write pending on the next edge.
        regWrite_en    = 1'b1;
        write_addr     = 5'd7;
        write_reg_data = 64'h1234;
        rst = 1'b0;
        #1;
        check("async_rst_r7",  read_data_1, 64'd0);
        check("async_rst_r31", read_data_2, 64'd0);
        step();
        regWrite_en = 1'b0;
        rst = 1'b1;
        #1;
        check("post_rst_r7",  read_data_1, 64'd0);
        check("post_rst_r31", read_data_2, 64'd0);
        step();

        wr(5'd16, 64'd42069);
        read_1_addr = 5'd16;
        read_2_addr = 5'd16;
        #1;
        check("wr16_rd1", read_data_1, 64'd42069);
        check("wr16_rd2", read_data_2, 64'd42069);
        check("model_pin_r16", exp_rd(5'd16), 64'd42069);

        write_addr     = 5'd16;
        write_reg_data = 64'hDEAD;
        step();
        check("en_gate_r16", read_data_1, 64'd42069);

        wr(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        read_1_addr = 5'd0;
        read_2_addr = 5'd0;
        #1;
        check("r0_rd1", read_data_1, 64'd0);
        check("r0_rd2", read_data_2, 64'd0);

        wr(5'd5, 64'd7);
        regWrite_en    = 1'b1;
        write_addr     = 5'd5;
        write_reg_data = 64'd99;
        read_1_addr    = 5'd5;
        read_2_addr    = 5'd6;
        #1;
        check("bypass_pre_edge", read_data_1, 64'd99);
        check("bypass_other",    read_data_2, 64'd0);
        step();
        regWrite_en = 1'b0;
        check("bypass_post_edge", read_data_1, 64'd99);

        wr(5'd3, 64'h1111);
        wr(5'd31, 64'hFFFF_0000_FFFF_0000);
        read_1_addr = 5'd3;
        read_2_addr = 5'd31;
        #1;
        check("dual_rd1_r3",  read_data_1, 64'h1111);
        check("dual_rd2_r31", read_data_2, 64'hFFFF_0000_FFFF_0000);
        read_1_addr = 5'd31;
        read_2_addr = 5'd3;
        #1;
        check("swap_rd1_r31", read_data_1, 64'hFFFF_0000_FFFF_0000);
        check("swap_rd2_r3",  read_data_2, 64'h1111);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
